// File: rtl/mem_wr_pkg.sv
// ---------------------------------------------------------------------------
// mem_wr_pkg
// Shared definitions for the burst write path: default widths and the state
// encoding of the burst writer FSM.
//
// Contents:
//   DEF_DATA_WIDTH  default width of data beats and memory words
//   DEF_ADDR_WIDTH  default memory address width
//   wr_state_t      IDLE / WRITE / DONE states of mem_burst_writer
// ---------------------------------------------------------------------------
package mem_wr_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_t;

endpackage : mem_wr_pkg

// File: rtl/burst_addr_ctr.sv
// ---------------------------------------------------------------------------
// burst_addr_ctr
// Address / beat bookkeeping for one burst. On load it captures the base
// address and the beat count; on every step the address advances by one
// (wrapping modulo 2^ADDR_WIDTH) and the remaining count drops by one.
// o_last tells the owner that the beat about to be taken is the final one.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   i_load     in   capture i_base / i_length this cycle
//   i_base     in   first write address of the burst
//   i_length   in   beats in the burst, 0..2^ADDR_WIDTH
//   i_step     in   one beat consumed this cycle
//   o_addr     out  address for the current beat
//   o_last     out  exactly one beat remains
// ---------------------------------------------------------------------------
module burst_addr_ctr
    import mem_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH:0]   i_length,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;

    // The remaining count is one bit wider than the address so that a full
    // sweep of the memory (2^ADDR_WIDTH beats) can be represented. The
    // address simply overflows to zero, which gives the modulo wrap for free.
    // Load has priority over step; the owner never asserts both together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= i_length;
        end else if (i_step) begin
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - REM_ONE;
        end
    end

    // Flag the final beat so the FSM can move to DONE on the same edge that
    // takes it, keeping done aligned with the final write pulse.
    always_comb begin
        o_addr = r_addr;
        o_last = (r_remaining == REM_ONE);
    end

endmodule : burst_addr_ctr

// File: rtl/mem_burst_writer.sv
// ---------------------------------------------------------------------------
// mem_burst_writer
// Write-side companion to the synchronous ROM/RAM blocks. A burst command
// (base address, length) is accepted in IDLE, after which a valid/ready
// stream is turned into sequential single-cycle writes to a synchronous
// single-port memory. A running checksum of the accepted beats lets the read
// side verify the burst, and done pulses once when the burst completes.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   burst request, honoured only in IDLE
//   base_addr  in   first write address, latched on accepted start
//   length     in   beats in burst (0..2^ADDR_WIDTH), latched on accepted start
//   abort      in   cancel the burst in progress
//   in_data    in   stream data
//   in_valid   in   stream data valid
//   in_ready   out  a beat is accepted this cycle when in_valid is also high
//   we         out  memory write enable (registered)
//   waddr      out  memory write address (registered)
//   wdata      out  memory write data (registered)
//   busy       out  FSM not in IDLE
//   done       out  one-cycle pulse at burst completion
//   checksum   out  sum of accepted beats modulo 2^DATA_WIDTH
// ---------------------------------------------------------------------------
module mem_burst_writer
    import mem_wr_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    wr_state_t             r_state;
    wr_state_t             w_nextState;

    logic                  w_load;
    logic                  w_beat;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_checksum;

    // A command is only taken while idle; start in WRITE or DONE is ignored,
    // so the earliest follow-on burst begins the cycle after done.
    // A beat is taken only when the block is ready, and ready is only ever
    // raised in WRITE, so stream activity elsewhere never consumes data.
    always_comb begin
        w_load = (r_state == IDLE) && start;
        w_beat = in_valid && in_ready;
    end

    // Address and beat counting live in their own block so the FSM below
    // only has to look at the last-beat flag.
    burst_addr_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addrCtr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_base   (base_addr),
        .i_length (length),
        .i_step   (w_beat),
        .o_addr   (w_addr),
        .o_last   (w_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A zero-length burst skips WRITE and goes straight to
    // DONE so it still produces a done pulse with no writes. Abort wins over
    // a pending beat (in_ready is already low while abort is high) and drops
    // back to IDLE without passing through DONE, so no done pulse is seen.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = (length != '0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (abort) begin
                    w_nextState = IDLE;
                end else if (w_beat && w_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output logic decoded from the current state. done is high for the
    // single DONE cycle, which is the same cycle the registered write port
    // presents the final beat.
    always_comb begin
        in_ready = 1'b0;
        busy     = (r_state != IDLE);
        done     = 1'b0;
        unique case (r_state)
            IDLE:    in_ready = 1'b0;
            WRITE:   in_ready = !abort;
            DONE:    done     = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Registered memory write port: an accepted beat is written exactly one
    // cycle later. When no beat is taken the enable drops but address and
    // data hold, so the memory bus does not toggle needlessly during stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_beat;
            if (w_beat) begin
                r_waddr <= w_addr;
                r_wdata <= in_data;
            end
        end
    end

    // Running checksum of accepted beats, truncated to the data width.
    // It restarts on each accepted command and otherwise holds, so after
    // done (or an abort) the read side can still pick up the final sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_load) begin
            r_checksum <= '0;
        end else if (w_beat) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    // Drive the registered values onto the ports.
    always_comb begin
        we       = r_we;
        waddr    = r_waddr;
        wdata    = r_wdata;
        checksum = r_checksum;
    end

endmodule : mem_burst_writer

// File: tb/tb_mem_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_writer
// Drives mem_burst_writer one cycle at a time against a cycle model of the
// burst protocol. Every accepted beat pushes its expected (address, data)
// write into a queue; every write pulse seen on the memory port pops and
// compares it. A writable copy of the synchronous ROM model captures the
// writes so bursts can be read back afterwards.
// ---------------------------------------------------------------------------
module tb_mem_burst_writer;
    import mem_wr_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        sbQ[$];
    logic [7:0] mem    [256];
    logic [7:0] expMem [256];
    int         hits   [256];

    int         vectors;
    int         miscompares;
    int         weCount;

    wr_state_t  mState;
    logic [7:0] mAddr;
    logic [8:0] mRem;
    logic [7:0] mSum;
    logic       mWe;
    logic [7:0] mLastAddr;
    logic [7:0] mLastData;
    bit         mValid;

    mem_burst_writer #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Writable synchronous memory fed by the DUT write port.
    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, check the outputs
    // the DUT is presenting, then advance the model across the next rising
    // edge.
    task automatic applyStimulus(input logic rstnV, input logic startV,
                                 input logic [7:0] baseV, input logic [8:0] lenV,
                                 input logic abortV, input logic [7:0] dataV,
                                 input logic validV);
        wr_t e;
        logic beat;
        @(negedge clk);
        rst_n     = rstnV;
        start     = startV;
        base_addr = baseV;
        length    = lenV;
        abort     = abortV;
        in_data   = dataV;
        in_valid  = validV;
        #1;
        if (mValid) begin
            checkOutput("we", {31'd0, we}, {31'd0, mWe});
            if (we) begin
                weCount++;
                hits[waddr]++;
                if (sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    checkOutput("waddr", {24'd0, waddr}, {24'd0, e.a});
                    checkOutput("wdata", {24'd0, wdata}, {24'd0, e.d});
                    mLastAddr = e.a;
                    mLastData = e.d;
                end
            end else begin
                checkOutput("waddr_hold", {24'd0, waddr}, {24'd0, mLastAddr});
                checkOutput("wdata_hold", {24'd0, wdata}, {24'd0, mLastData});
            end
            checkOutput("in_ready", {31'd0, in_ready},
                        {31'd0, (mState == WRITE) && !abortV});
            checkOutput("busy", {31'd0, busy}, {31'd0, mState != IDLE});
            checkOutput("done", {31'd0, done}, {31'd0, mState == DONE});
            checkOutput("checksum", {24'd0, checksum}, {24'd0, mSum});
        end

        beat = rstnV && (mState == WRITE) && validV && !abortV;
        if (!rstnV) begin
            mState    = IDLE;
            mWe       = 1'b0;
            mLastAddr = 8'h00;
            mLastData = 8'h00;
            mSum      = 8'h00;
            mAddr     = 8'h00;
            mRem      = 9'd0;
            sbQ.delete();
            mValid    = 1'b1;
        end else begin
            mWe = beat;
            case (mState)
                IDLE: begin
                    if (startV) begin
                        mAddr  = baseV;
                        mRem   = lenV;
                        mSum   = 8'h00;
                        mState = (lenV != 9'd0) ? WRITE : DONE;
                    end
                end
                WRITE: begin
                    if (abortV) begin
                        mState = IDLE;
                    end else if (beat) begin
                        sbQ.push_back('{a: mAddr, d: dataV});
                        expMem[mAddr] = dataV;
                        mAddr = mAddr + 8'd1;
                        mSum  = mSum + dataV;
                        if (mRem == 9'd1) mState = DONE;
                        mRem = mRem - 9'd1;
                    end
                end
                default: mState = IDLE;
            endcase
        end
    endtask

    task automatic idleCycles(input int n, input logic validV);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'h5A, validV);
    endtask

    task automatic readBack(input string tag, input logic [7:0] base, input int n);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            checkOutput(tag, {24'd0, mem[a]}, {24'd0, expMem[a]});
        end
    endtask

    initial begin
        logic [7:0] stallData [6];
        logic       stallValid [6];
        vectors     = 0;
        miscompares = 0;
        weCount     = 0;
        mValid      = 1'b0;
        mState      = IDLE;
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = 8'h00;
        length      = 9'd0;
        abort       = 1'b0;
        in_data     = 8'h00;
        in_valid    = 1'b0;

        applyStimulus(0, 0, 8'h00, 9'd0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 9'd0, 0, 8'h00, 1);
        idleCycles(2, 1);

        // Basic burst; a start during DONE must be ignored.
        $display("[TB] basic burst");
        weCount = 0;
        applyStimulus(1, 1, 8'h10, 9'd4, 0, 8'h00, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'(i), 1);
        applyStimulus(1, 1, 8'h70, 9'd2, 0, 8'h00, 0);
        idleCycles(2, 0);
        checkOutput("basic_sum", {24'd0, checksum}, 32'h0A);
        checkOutput("basic_wes", weCount, 4);
        readBack("basic_rd", 8'h10, 4);

        // Address wrap through zero.
        $display("[TB] wrap burst");
        applyStimulus(1, 1, 8'hFE, 9'd3, 0, 8'h00, 0);
        applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'hAA, 1);
        applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'hBB, 1);
        applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'hCC, 1);
        idleCycles(3, 0);
        checkOutput("wrap_sum", {24'd0, checksum}, 32'h31);
        readBack("wrap_rd", 8'hFE, 3);

        // Stalled stream.
        $display("[TB] stalled burst");
        stallData  = '{8'h31, 8'hEE, 8'hEE, 8'h32, 8'hEE, 8'h33};
        stallValid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        weCount = 0;
        applyStimulus(1, 1, 8'h40, 9'd3, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1, 0, 8'h00, 9'd0, 0, stallData[i], stallValid[i]);
        idleCycles(3, 1);
        checkOutput("stall_wes", weCount, 3);
        checkOutput("stall_sum", {24'd0, checksum}, 32'h96);
        readBack("stall_rd", 8'h40, 3);

        // Zero-length burst.
        $display("[TB] zero-length burst");
        weCount = 0;
        applyStimulus(1, 1, 8'h33, 9'd0, 0, 8'h00, 0);
        idleCycles(3, 1);
        checkOutput("zero_wes", weCount, 0);
        checkOutput("zero_sum", {24'd0, checksum}, 32'h00);

        // Full-memory burst starting mid-range.
        $display("[TB] full-length burst");
        for (int i = 0; i < 256; i++) hits[i] = 0;
        weCount = 0;
        applyStimulus(1, 1, 8'h80, 9'd256, 0, 8'h00, 0);
        for (int i = 0; i < 256; i++)
            applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'($urandom_range(0, 255)), 1);
        idleCycles(3, 0);
        checkOutput("full_wes", weCount, 256);
        for (int i = 0; i < 256; i++) checkOutput("full_hits", hits[i], 1);
        readBack("full_rd", 8'h00, 256);

        // Abort after three beats, with start pulses during WRITE.
        $display("[TB] abort burst");
        weCount = 0;
        applyStimulus(1, 1, 8'h20, 9'd8, 0, 8'h00, 0);
        applyStimulus(1, 1, 8'h99, 9'd2, 0, 8'h11, 1);
        applyStimulus(1, 1, 8'h99, 9'd2, 0, 8'h22, 1);
        applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'h33, 1);
        applyStimulus(1, 0, 8'h00, 9'd0, 1, 8'h44, 1);
        idleCycles(3, 1);
        checkOutput("abort_wes", weCount, 3);
        checkOutput("abort_sum", {24'd0, checksum}, 32'h66);
        readBack("abort_rd", 8'h20, 3);

        // Reset in the middle of a burst.
        $display("[TB] reset mid-burst");
        weCount = 0;
        applyStimulus(1, 1, 8'h60, 9'd5, 0, 8'h00, 0);
        applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'h05, 1);
        applyStimulus(1, 0, 8'h00, 9'd0, 0, 8'h06, 1);
        applyStimulus(0, 0, 8'h00, 9'd0, 0, 8'h07, 1);
        idleCycles(4, 1);
        checkOutput("reset_wes", weCount, 2);
        checkOutput("reset_sum", {24'd0, checksum}, 32'h00);

        checkOutput("sb_empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_burst_writer

// File: doc/mem_burst_writer.md
Name: mem_burst_writer

Overview:
Write-side companion to the team's synchronous ROM/RAM blocks. Accepts a burst command (base address, length), then takes a valid/ready data stream and drives sequential single-cycle writes into a synchronous single-port memory of DATA_WIDTH x 2^ADDR_WIDTH. It keeps a running checksum so the read side can verify the burst, and pulses done when the burst completes.

Parameters:
DATA_WIDTH, 8, width of data beats and memory words
ADDR_WIDTH, 8, memory address width; addresses wrap modulo 2^ADDR_WIDTH

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  burst request; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first write address, latched on accepted start
length  input  ADDR_WIDTH+1  beats in burst (0..2^ADDR_WIDTH), latched on accepted start
abort  input  1  cancels an in-progress burst
in_data  input  DATA_WIDTH  stream data
in_valid  input  1  stream data valid
in_ready  output  1  block accepts a beat this cycle
we  output  1  memory write enable (registered)
waddr  output  ADDR_WIDTH  memory write address (registered)
wdata  output  DATA_WIDTH  memory write data (registered)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at burst completion
checksum  output  DATA_WIDTH  sum of accepted beats mod 2^DATA_WIDTH

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; we=0, waddr=0, wdata=0, done=0, checksum=0; busy=0, in_ready=0. Reset overrides everything, including mid-burst. A partially written burst is abandoned with no done.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start=1: latch base_addr into addr counter and length into remaining, clear checksum.
  - Next state is WRITE if length!=0, else DONE, which completes a zero-length burst with no writes.
- WRITE:
  - in_ready = !abort (combinational).
  - Beat accepted when in_valid && in_ready. On the next cycle: we=1, waddr=addr, wdata=in_data. Accept-to-write latency is exactly 1 cycle.
  - On each accepted beat: addr <= addr+1 mod 2^ADDR_WIDTH, so 0xFF wraps to 0x00. Also remaining <= remaining-1 and checksum <= checksum+in_data, truncated.
  - Accepted beat with remaining==1: go to DONE.
  - No beat in a cycle: we=0 next cycle; waddr and wdata hold their last values.
  - abort=1: no beat accepted that cycle; go to IDLE next cycle; no done pulse; checksum holds the partial sum.
- DONE:
  - done=1 for exactly this cycle. It coincides with the final we pulse, if any.
  - in_ready=0. Go to IDLE.
  - start is ignored here and in WRITE; it is honoured only in IDLE, so the earliest next burst begins one cycle after done.
- busy = (state != IDLE).
- checksum holds after done until the next accepted start or reset.
- length = 2^ADDR_WIDTH (256 by default) writes every location exactly once. Nonzero base_addr wraps through 0.
- in_valid high outside WRITE is ignored (in_ready=0); beats are never dropped silently.

Decomposition:
- Package mem_wr_pkg: typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t; localparams for default widths.
- One natural sub-module: burst_addr_ctr, which loads base/length, increments addr with wrap, decrements remaining and flags last. The top holds the FSM, stream handshake, registered write port and checksum.
- Bench reuses the existing synchronous ROM-style memory model, made writable, as the write target and read-back checker.

Test Plan:
- Basic burst: start, base=0x10, length=4, data 0x01,0x02,0x03,0x04 with in_valid held high -> we pulses at addrs 0x10..0x13 in 4 consecutive cycles, each one cycle after acceptance; done coincides with the 4th we; checksum=0x0A; read-back matches.
- Wrap: base=0xFE, length=3, data 0xAA,0xBB,0xCC -> writes at 0xFE, 0xFF, 0x00; checksum=0x31.
- Stalls: length=3, in_valid toggled 1,0,0,1,0,1 -> exactly 3 we pulses, none during gaps, waddr/wdata hold during gaps; done after the 3rd write.
- Zero length and full length: length=0 -> done one cycle after IDLE start, no we, checksum=0. Length=256, base=0x80 -> 256 writes covering every address once.
- Abort and start-while-busy: length=8, abort after 3 beats -> 3 writes, no done, IDLE next cycle, checksum = sum of 3 beats. A start pulse during WRITE is ignored, so base/length do not change.
- Reset mid-burst: rst_n=0 for 1 cycle after 2 of 5 beats -> next cycle all outputs at reset values, state IDLE, no further we, no done.
